mem_arbiter: RTL

- Shares one unified memory port between the CPU's instruction-fetch side and its data-access side.
- Sequences one memory transaction at a time, returns read data to the requester, and drives the 2-bit cacheStall the CPU consumes.
- Data requests have priority. A skip counter guarantees instruction fetches cannot starve.
- Sits between cpu (i_/d_ sides) and the memory model.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/arb_skip_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: word width, arbiter state encodings and
// cacheStall bit positions.
package cpu_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  localparam int STALL_I = 0;
  localparam int STALL_D = 1;

endpackage

// File: rtl/arb_skip_counter.sv
// Saturating up-counter with synchronous clear; at_max flags the saturation value.
// Clear wins over increment.
module arb_skip_counter #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and data access.
// Data has priority; the skip counter forces an I grant after MAX_SKIP I-losses.
//
// state      | meaning
// ARB_IDLE   | no transaction, arbitrate eligible requests
// ARB_BUSY_I | instruction read strobed, waiting for m_ack
// ARB_BUSY_D | data read/write strobed, waiting for m_ack
module mem_arbiter #(
  parameter int WORD_SIZE = cpu_pkg::WORD_SIZE,
  parameter int MAX_SKIP  = 4,
  parameter int SKIP_W    = 3
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_valid,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_valid,
  output logic [1:0]           cacheStall,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  input  logic                 m_ack
);

  cpu_pkg::arb_state_e state_q, state_d;

  logic                 m_read_q, m_read_d;
  logic                 m_write_q, m_write_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 i_valid_q, i_valid_d;
  logic                 d_valid_q, d_valid_d;

  logic              skip_inc, skip_clr, skip_at_max;
  logic [SKIP_W-1:0] skip_cnt;

  // A request still held during its own completion cycle must not be re-granted.
  logic i_elig, d_elig;
  assign i_elig = i_req & ~i_valid_q;
  assign d_elig = d_req & ~d_valid_q;

  arb_skip_counter #(.W(SKIP_W), .MAX(MAX_SKIP)) u_skip (
    .clk    (Clk),
    .rst_n  (Reset_N),
    .inc    (skip_inc),
    .clr    (skip_clr),
    .cnt    (skip_cnt),
    .at_max (skip_at_max)
  );

  always_comb begin
    state_d   = state_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    skip_inc  = 1'b0;
    skip_clr  = 1'b0;
    case (state_q)
      cpu_pkg::ARB_IDLE: begin
        if (d_elig && (!i_elig || !skip_at_max)) begin
          state_d   = cpu_pkg::ARB_BUSY_D;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          m_read_d  = ~d_we;
          m_write_d = d_we;
          skip_inc  = i_elig;
        end else if (i_elig) begin
          state_d   = cpu_pkg::ARB_BUSY_I;
          addr_d    = i_addr;
          m_read_d  = 1'b1;
          m_write_d = 1'b0;
          skip_clr  = 1'b1;
        end
      end
      cpu_pkg::ARB_BUSY_I: begin
        if (m_ack) begin
          state_d   = cpu_pkg::ARB_IDLE;
          m_read_d  = 1'b0;
          i_rdata_d = m_rdata;
          i_valid_d = 1'b1;
        end
      end
      cpu_pkg::ARB_BUSY_D: begin
        if (m_ack) begin
          state_d   = cpu_pkg::ARB_IDLE;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          if (m_read_q) d_rdata_d = m_rdata;
          d_valid_d = 1'b1;
        end
      end
      default: state_d = cpu_pkg::ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q   <= cpu_pkg::ARB_IDLE;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign m_readM   = m_read_q;
  assign m_writeM  = m_write_q;
  assign m_address = addr_q;
  assign m_wdata   = wdata_q;

  // Gated by reset so every output reads 0 while Reset_N is low.
  assign cacheStall[cpu_pkg::STALL_I] = Reset_N & i_req & ~i_valid_q;
  assign cacheStall[cpu_pkg::STALL_D] = Reset_N & d_req & ~d_valid_q;

endmodule
